// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Drain stage for the project FIFO. Whenever the FIFO holds a word and
// transmission is enabled, the block pops exactly one word and sends it on a
// UART-style line. Each frame has 1 start bit, DATA_WIDTH data bits sent
// LSB-first, and 1 stop bit. There is no parity bit. Bit timing is a fixed
// divider of CLKS_PER_BIT system clocks per serial bit.
//
// Ports
//   clk          system clock; all state changes on its rising edge
//   reset        asynchronous, active-high reset
//   enable       allows new frames to start (sampled in IDLE only)
//   fifo_empty   FIFO empty flag (sampled in IDLE only)
//   fifo_data    FIFO registered read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   one-cycle FIFO read strobe, one pulse per frame
//   tx           serial output, idle high
//   busy         high whenever the FSM is not in IDLE
//   frames_sent  count of completed frames, wraps at 2^COUNT_WIDTH
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   fifo_empty,
   input  logic [DATA_WIDTH-1:0]  fifo_data,
   output logic                   fifo_rd_en,
   output logic                   tx,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] frames_sent
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      LOAD,
      START,
      DATA,
      STOP
   } state_t;

   state_t                  state;
   logic [BAUD_W-1:0]       baud;
   logic [BIT_W-1:0]        bit_idx;
   logic [DATA_WIDTH-1:0]   shift;
   logic [DATA_WIDTH-1:0]   shift_next;
   logic                    baud_done;

   assign baud_done  = (baud == BAUD_LAST);
   // Next bit to present is taken from the already-shifted value, so tx stays
   // a registered copy of shift[0] throughout DATA.
   assign shift_next = shift >> 1;

   // NOTE: all sequential state uses non-blocking assignments, so every
   // register samples the values from before this edge regardless of the order
   // of statements.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         tx          <= 1'b1;
         fifo_rd_en  <= 1'b0;
         busy        <= 1'b0;
         frames_sent <= '0;
         baud        <= '0;
         bit_idx     <= '0;
         shift       <= '0;
      end else begin
         // The read strobe is a single-cycle pulse; only IDLE raises it.
         fifo_rd_en <= 1'b0;
         case (state)
            IDLE: begin
               tx   <= 1'b1;
               baud <= '0;
               if (enable && !fifo_empty) begin
                  state      <= REQ;
                  fifo_rd_en <= 1'b1;
                  busy       <= 1'b1;
               end
            end

            REQ: begin
               state <= LOAD;
            end

            // The FIFO presents the popped word during this cycle.
            LOAD: begin
               shift <= fifo_data;
               baud  <= '0;
               tx    <= 1'b0;
               state <= START;
            end

            START: begin
               if (baud_done) begin
                  baud    <= '0;
                  bit_idx <= '0;
                  tx      <= shift[0];
                  state   <= DATA;
               end else begin
                  baud <= baud + 1'b1;
               end
            end

            DATA: begin
               if (baud_done) begin
                  baud <= '0;
                  if (bit_idx == BIT_LAST) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     shift   <= shift_next;
                     tx      <= shift_next[0];
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end

            STOP: begin
               if (baud_done) begin
                  baud        <= '0;
                  frames_sent <= frames_sent + 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  baud <= baud + 1'b1;
               end
            end

            default: begin
               tx    <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
